usr_serial_tx_ctrl: RTL and testbench

//  Sequencer that sits directly upstream of Univ_Shift_Reg and turns it into a

---
 rtl/usr_serial_tx_ctrl.sv | 135 +++++++++++++
 tb/tb_usr_serial_tx_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/usr_serial_tx_ctrl.sv
// rtl/usr_serial_tx_ctrl.sv - sequencer driving Univ_Shift_Reg as a parallel-to-serial transmitter
//
// Accepts one WIDTH-bit word on in_data/in_valid/in_ready, loads it into the
// downstream universal shift register, then shifts it out one bit per clock,
// LSB-first or MSB-first as selected by msb_first when the word was accepted.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low
//   in_data    parallel word to transmit
//   in_valid   in_data valid
//   in_ready   block can accept a word this cycle
//   msb_first  1 = MSB first, 0 = LSB first (captured with the word)
//   usr_q      q output of the downstream shift register
//   usr_d      d input to the shift register (registered copy of the word)
//   usr_ctrl   00 hold, 01 shift left, 10 shift right, 11 load
//   ser_out    serial bit, meaningful while ser_valid = 1
//   ser_valid  high for exactly WIDTH consecutive cycles per word
//   done       one-cycle pulse after the last bit
module usr_serial_tx_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             msb_first,
    input  logic [WIDTH-1:0] usr_q,
    output logic [WIDTH-1:0] usr_d,
    output logic [1:0]       usr_ctrl,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             msb_latch;
    // Holds in_ready low until the first edge after reset release, so the
    // ready output is purely registered rather than gated by the reset pin.
    logic             armed;
    logic             accept;

    // Only the two end bits of the register are observed.
    logic unused_q_bits;
    assign unused_q_bits = ^usr_q;

    assign accept = (state == S_IDLE) && armed && in_valid;

    // State register and datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            usr_d     <= '0;
            msb_latch <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        usr_d     <= in_data;
                        msb_latch <= msb_first;
                    end
                end
                S_LOAD: begin
                    cnt <= '0;
                end
                S_SHIFT: begin
                    // Counter parks at the last index instead of wrapping.
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_SHIFT;
            S_SHIFT: if (cnt == CNT_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        usr_ctrl  = 2'b00;
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = armed;
            end
            S_LOAD: begin
                usr_ctrl = 2'b11;
            end
            S_SHIFT: begin
                // MSB-first drains from the top, so shift left; LSB-first shifts right.
                usr_ctrl  = msb_latch ? 2'b01 : 2'b10;
                ser_valid = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign ser_out = ser_valid & (msb_latch ? usr_q[WIDTH-1] : usr_q[0]);

endmodule

// File: tb/tb_usr_serial_tx_ctrl.sv
// tb/tb_usr_serial_tx_ctrl.sv - self-checking bench for usr_serial_tx_ctrl
module tb_usr_serial_tx_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       msb_first;
    logic [7:0] usr_q;
    logic [7:0] usr_d;
    logic [1:0] usr_ctrl;
    logic       ser_out;
    logic       ser_valid;
    logic       done;

    int errors = 0;
    int checks = 0;

    usr_serial_tx_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .msb_first (msb_first),
        .usr_q     (usr_q),
        .usr_d     (usr_d),
        .usr_ctrl  (usr_ctrl),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural universal shift register downstream of the DUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            usr_q <= 8'h00;
        end else begin
            case (usr_ctrl)
                2'b01:   usr_q <= {usr_q[6:0], 1'b0};
                2'b10:   usr_q <= {1'b1, usr_q[7:1]};
                2'b11:   usr_q <= usr_d;
                default: usr_q <= usr_q;
            endcase
        end
    end

    // exp_seq lists the bits in transmission order, first bit in [7].
    typedef struct {
        logic [7:0] data;
        logic       msb;
        logic [7:0] exp_seq;
        logic [1:0] exp_ctrl;
        logic       junk;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left at a falling edge with the DUT idle.
    task automatic send_word(input int n, input vec_t v);
        chk($sformatf("v%0d_ready", n), 32'(in_ready), 32'd1);
        in_data   = v.data;
        msb_first = v.msb;
        in_valid  = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_load_ctrl", n), 32'(usr_ctrl), 32'd3);
        chk($sformatf("v%0d_load_ready", n), 32'(in_ready), 32'd0);
        chk($sformatf("v%0d_load_sv", n), 32'(ser_valid), 32'd0);
        in_valid = 1'b0;
        if (v.junk) begin
            in_data   = ~v.data;
            msb_first = ~v.msb;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_sv%0d", n, i), 32'(ser_valid), 32'd1);
            chk($sformatf("v%0d_bit%0d", n, i), 32'(ser_out), 32'(v.exp_seq[7-i]));
            chk($sformatf("v%0d_ctrl%0d", n, i), 32'(usr_ctrl), 32'(v.exp_ctrl));
            chk($sformatf("v%0d_done%0d", n, i), 32'(done), 32'd0);
            if (v.junk) begin
                in_valid  = (i < 6) && (i % 2 == 0);
                in_data   = 8'($urandom);
                msb_first = ~msb_first;
            end
        end
        @(negedge clk);
        chk($sformatf("v%0d_done", n), 32'(done), 32'd1);
        chk($sformatf("v%0d_done_sv", n), 32'(ser_valid), 32'd0);
        chk($sformatf("v%0d_done_ctrl", n), 32'(usr_ctrl), 32'd0);
        chk($sformatf("v%0d_done_ready", n), 32'(in_ready), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_idle_done", n), 32'(done), 32'd0);
        chk($sformatf("v%0d_idle_ready", n), 32'(in_ready), 32'd1);
        chk($sformatf("v%0d_idle_ctrl", n), 32'(usr_ctrl), 32'd0);
    endtask

    initial begin
        int   loads[$];
        logic bits[$];
        int   done_seen;
        logic [15:0] b2b_exp;

        vecs[0] = '{data: 8'hA5, msb: 1'b0, exp_seq: 8'b10100101, exp_ctrl: 2'b10, junk: 1'b0};
        vecs[1] = '{data: 8'hA5, msb: 1'b1, exp_seq: 8'b10100101, exp_ctrl: 2'b01, junk: 1'b0};
        vecs[2] = '{data: 8'h01, msb: 1'b1, exp_seq: 8'b00000001, exp_ctrl: 2'b01, junk: 1'b0};
        vecs[3] = '{data: 8'h81, msb: 1'b0, exp_seq: 8'b10000001, exp_ctrl: 2'b10, junk: 1'b0};
        vecs[4] = '{data: 8'hC6, msb: 1'b1, exp_seq: 8'b11000110, exp_ctrl: 2'b01, junk: 1'b1};
        vecs[5] = '{data: 8'h2B, msb: 1'b0, exp_seq: 8'b11010100, exp_ctrl: 2'b10, junk: 1'b1};
        vecs[6] = '{data: 8'h3C, msb: 1'b0, exp_seq: 8'b00111100, exp_ctrl: 2'b10, junk: 1'b0};

        reset     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        msb_first = 1'b0;

        // Reset held, then released with in_valid low.
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_ctrl", 32'(usr_ctrl), 32'd0);
        chk("rst_sv", 32'(ser_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_usr_d", 32'(usr_d), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d_ctrl", i), 32'(usr_ctrl), 32'd0);
            chk($sformatf("idle%0d_ready", i), 32'(in_ready), 32'd1);
            chk($sformatf("idle%0d_sv", i), 32'(ser_valid), 32'd0);
            chk($sformatf("idle%0d_done", i), 32'(done), 32'd0);
        end

        // Table vectors; junk ones wiggle inputs mid-word and must see nothing queued.
        for (int n = 0; n < 6; n++) begin
            send_word(n, vecs[n]);
            if (vecs[n].junk) begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk($sformatf("v%0d_noq_ctrl%0d", n, k), 32'(usr_ctrl), 32'd0);
                    chk($sformatf("v%0d_noq_sv%0d", n, k), 32'(ser_valid), 32'd0);
                end
            end
        end

        // Back-to-back with in_valid held high: 0F then F0, both LSB first.
        in_data   = 8'h0F;
        msb_first = 1'b0;
        in_valid  = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (usr_ctrl == 2'b11) loads.push_back(k);
            if (ser_valid) bits.push_back(ser_out);
            in_data = 8'hF0;
            if (loads.size() >= 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("b2b_loads", 32'(loads.size()), 32'd2);
        if (loads.size() == 2) begin
            chk("b2b_first_load", 32'(loads[0]), 32'd1);
            chk("b2b_spacing", 32'(loads[1] - loads[0]), 32'd11);
        end
        chk("b2b_bits", 32'(bits.size()), 32'd16);
        b2b_exp = 16'b1111000000001111;
        if (bits.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("b2b_bit%0d", i), 32'(bits[i]), 32'(b2b_exp[15-i]));
            end
        end

        // Reset after the 3rd bit of FF.
        @(negedge clk);
        in_data   = 8'hFF;
        msb_first = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("ab_bit%0d", i), 32'(ser_out), 32'd1);
            chk($sformatf("ab_sv%0d", i), 32'(ser_valid), 32'd1);
        end
        #2 reset = 1'b0;
        #1;
        chk("ab_sv", 32'(ser_valid), 32'd0);
        chk("ab_ctrl", 32'(usr_ctrl), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (ser_valid) done_seen++;
        end
        chk("ab_no_done", 32'(done_seen), 32'd0);
        send_word(6, vecs[6]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
